// File: rtl/nios2_debug_slave_cmd_bridge.sv
// rtl/nios2_debug_slave_cmd_bridge.sv - sysclk-side JTAG debug command bridge
// Synchronises tck-domain update strobes, queues {ir, dr} captures and issues one-hot action pulses.
module nios2_debug_slave_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DW          = 38,
    parameter int ENABLE_BIT  = 37,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [DW-1:0]                 sr,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic                          act_ready,
    input  logic                          clr_overflow,
    output logic                          act_valid,
    output logic [DW-1:0]                 jdo,
    output logic [IR_WIDTH-1:0]           act_ir,
    output logic [(2**IR_WIDTH)-1:0]      take_action,
    output logic [(2**IR_WIDTH)-1:0]      take_no_action,
    output logic                          ir_update,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int NA = 2**IR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = IR_WIDTH + DW;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic                   udr_edge_q, udr_edge_d;
    logic                   uir_edge_q, uir_edge_d;
    logic                   cap_q, cap_d;
    logic                   ir_update_q, ir_update_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q, count_d;
    logic [DW-1:0]          jdo_q, jdo_d;
    logic [IR_WIDTH-1:0]    act_ir_q, act_ir_d;
    logic [NA-1:0]          ta_q, ta_d;
    logic [NA-1:0]          tna_q, tna_d;
    logic                   overflow_q, overflow_d;

    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   head_is_new;
    logic [EW-1:0]          wdata;
    logic [EW-1:0]          head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_q  <= '0;
            uir_sync_q  <= '0;
            udr_edge_q  <= 1'b0;
            uir_edge_q  <= 1'b0;
            cap_q       <= 1'b0;
            ir_update_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            jdo_q       <= '0;
            act_ir_q    <= '0;
            ta_q        <= '0;
            tna_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            udr_sync_q  <= udr_sync_d;
            uir_sync_q  <= uir_sync_d;
            udr_edge_q  <= udr_edge_d;
            uir_edge_q  <= uir_edge_d;
            cap_q       <= cap_d;
            ir_update_q <= ir_update_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            jdo_q       <= jdo_d;
            act_ir_q    <= act_ir_d;
            ta_q        <= ta_d;
            tna_q       <= tna_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_edge_d  = udr_sync_q[SYNC_STAGES-1];
        uir_edge_d  = uir_sync_q[SYNC_STAGES-1];
        cap_d       = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
        ir_update_d = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;

        full  = (count_q == DEPTH_L);
        pop   = (count_q != '0) & act_ready;
        push  = cap_q & (~full | pop);
        drop  = cap_q & full & ~pop;
        wdata = {ir_in, sr};

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + LW'(push) - LW'(pop);

        // A push into a queue that is empty after this cycle's pop becomes the head directly.
        head_is_new = push & (count_q == LW'(pop));
        head        = head_is_new ? wdata : mem_q[rd_ptr_d];
        jdo_d       = jdo_q;
        act_ir_d    = act_ir_q;
        if (count_d != '0) begin
            jdo_d    = head[DW-1:0];
            act_ir_d = head[EW-1:DW];
        end

        ta_d  = '0;
        tna_d = '0;
        if (pop) begin
            if (jdo_q[ENABLE_BIT]) begin
                ta_d[act_ir_q] = 1'b1;
            end else begin
                tna_d[act_ir_q] = 1'b1;
            end
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    assign act_valid      = (count_q != '0);
    assign jdo            = jdo_q;
    assign act_ir         = act_ir_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign ir_update      = ir_update_q;
    assign fifo_level     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_bridge.sv
// tb/tb_nios2_debug_slave_cmd_bridge.sv - directed self-checking bench for the debug command bridge
module tb_nios2_debug_slave_cmd_bridge;
    logic        clk;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_udr;
    logic        vs_uir;
    logic        act_ready;
    logic        clr_overflow;
    logic        act_valid;
    logic [37:0] jdo;
    logic [1:0]  act_ir;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tna;
    } vec_t;

    vec_t vecs [5];

    nios2_debug_slave_cmd_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .act_ready      (act_ready),
        .clr_overflow   (clr_overflow),
        .act_valid      (act_valid),
        .jdo            (jdo),
        .act_ir         (act_ir),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic capture(input logic [1:0] ir, input logic [37:0] d);
        @(negedge clk);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        repeat (2) @(negedge clk);
        vs_udr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain_expect(input logic [37:0] first, input int n);
        @(negedge clk);
        act_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 64'(act_valid), 64'd1);
            check("drain_jdo", 64'(jdo), 64'(first + 38'(i)));
            @(negedge clk);
        end
        act_ready = 1'b0;
        check("drain_empty", 64'(act_valid), 64'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        ir_in        = '0;
        sr           = '0;
        vs_udr       = 1'b0;
        vs_uir       = 1'b0;
        act_ready    = 1'b0;
        clr_overflow = 1'b0;

        vecs[0] = '{ir: 2'b01, data: 38'h20_DEAD_BEEF, exp_ta: 4'b0010, exp_tna: 4'b0000};
        vecs[1] = '{ir: 2'b11, data: 38'h00_1234_5678, exp_ta: 4'b0000, exp_tna: 4'b1000};
        vecs[2] = '{ir: 2'b00, data: 38'h3F_FFFF_FFFF, exp_ta: 4'b0001, exp_tna: 4'b0000};
        vecs[3] = '{ir: 2'b10, data: 38'h1F_FFFF_FFFF, exp_ta: 4'b0000, exp_tna: 4'b0100};
        vecs[4] = '{ir: 2'b10, data: 38'h20_0000_0000, exp_ta: 4'b0100, exp_tna: 4'b0000};

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(act_valid), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ta", 64'({take_action, take_no_action}), 64'd0);
        check("rst_ovf", 64'({overflow, ir_update}), 64'd0);
        reset = 1'b0;

        // capture latency with act_ready already high
        @(negedge clk);
        ir_in     = 2'b01;
        sr        = 38'h20_DEAD_BEEF;
        vs_udr    = 1'b1;
        act_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_pre_valid", 64'(act_valid), 64'd0);
        end
        @(negedge clk);
        check("lat_valid", 64'(act_valid), 64'd1);
        check("lat_jdo", 64'(jdo), 64'h20_DEAD_BEEF);
        check("lat_ir", 64'(act_ir), 64'd1);
        @(negedge clk);
        check("lat_ta", 64'(take_action), 64'b0010);
        check("lat_tna", 64'(take_no_action), 64'd0);
        check("lat_after_valid", 64'(act_valid), 64'd0);
        @(negedge clk);
        check("lat_ta_end", 64'(take_action), 64'd0);
        check("lat_jdo_hold", 64'(jdo), 64'h20_DEAD_BEEF);
        act_ready = 1'b0;
        vs_udr    = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            capture(vecs[v].ir, vecs[v].data);
            check("vec_valid", 64'(act_valid), 64'd1);
            check("vec_jdo", 64'(jdo), 64'(vecs[v].data));
            check("vec_ir", 64'(act_ir), 64'(vecs[v].ir));
            act_ready = 1'b1;
            @(negedge clk);
            act_ready = 1'b0;
            check("vec_ta", 64'(take_action), 64'(vecs[v].exp_ta));
            check("vec_tna", 64'(take_no_action), 64'(vecs[v].exp_tna));
            @(negedge clk);
            check("vec_pulse_end", 64'({take_action, take_no_action}), 64'd0);
        end

        // five captures into a 4-deep queue with the consumer stalled
        for (int i = 1; i <= 5; i++) begin
            capture(2'b00, 38'(i));
        end
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_set", 64'(overflow), 64'd1);
        @(negedge clk);
        act_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain_jdo", 64'(jdo), 64'(i));
            @(negedge clk);
            check("ovf_b2b_tna", 64'(take_no_action), 64'b0001);
        end
        act_ready = 1'b0;
        check("ovf_drained", 64'(fifo_level), 64'd0);
        check("ovf_jdo_hold", 64'(jdo), 64'd4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // full queue: push and pop in the same cycle
        for (int i = 11; i <= 14; i++) begin
            capture(2'b00, 38'(i));
        end
        check("full_level", 64'(fifo_level), 64'd4);
        @(negedge clk);
        sr     = 38'd15;
        vs_udr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vs_udr = 1'b0;
        @(negedge clk);
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        check("full_pp_level", 64'(fifo_level), 64'd4);
        check("full_pp_ovf", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        drain_expect(38'd12, 4);

        // Update-IR strobe
        @(negedge clk);
        vs_uir = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check("uir_pre", 64'(ir_update), 64'd0);
        end
        @(negedge clk);
        check("uir_pulse", 64'(ir_update), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("uir_single", 64'(ir_update), 64'd0);
        end
        vs_uir = 1'b0;

        // long Update-DR level gives a single capture
        @(negedge clk);
        sr     = 38'd33;
        vs_udr = 1'b1;
        repeat (20) @(negedge clk);
        vs_udr = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_level", 64'(fifo_level), 64'd1);
        drain_expect(38'd33, 1);

        // async reset with queued entries and a pulse in flight
        capture(2'b01, 38'h20_0000_0001);
        capture(2'b01, 38'h20_0000_0002);
        check("rst2_level", 64'(fifo_level), 64'd2);
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        check("rst2_pulse", 64'(take_action), 64'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("rst2_valid", 64'(act_valid), 64'd0);
        check("rst2_ta", 64'({take_action, take_no_action}), 64'd0);
        check("rst2_level0", 64'(fifo_level), 64'd0);
        check("rst2_jdo", 64'({jdo, act_ir}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst2_quiet", 64'({act_valid, take_action, take_no_action}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
